// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial add/subtract datapaths: FSM encoding and default width.
package serial_arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : serial_arith_pkg

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder; ovf exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_if
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface : serial_adder_if

// File: rtl/serial_adder_fa.sv
// Single-bit adder cell used by the serial adder: a full adder built from two half adders.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial ripple adder, LSB first through one full-adder cell.
// Define SERIAL_ADD_OVF_EN to add the two's-complement overflow flag (bus.ovf).
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_n;
  logic             accept_c;
  logic             shift_c;
  logic             last_c;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and datapath controls
  always_comb begin
    state_n  = state;
    accept_c = 1'b0;
    shift_c  = 1'b0;
    last_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        shift_c = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_c  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_n  = SHIFT;
        end else begin
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Status flags registered from the next state so they line up with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_n == SHIFT);
      done_q <= (state_n == DONE);
    end
  end

  // Operand/result shift registers and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else if (accept_c) begin
      opa    <= bus.a;
      opb    <= bus.b;
      carry  <= bus.cin;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (shift_c) begin
      opa   <= {1'b0, opa[WIDTH-1:1]};
      opb   <= {1'b0, opb[WIDTH-1:1]};
      sum_q <= {fa_s, sum_q[WIDTH-1:1]};
      carry <= fa_co;
      if (last_c) cout_q <= fa_co;
      else        cnt    <= cnt + CNT_W'(1);
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // In the last cycle, carry holds the carry into the MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf_q <= 1'b0;
    else if (accept_c) ovf_q <= 1'b0;
    else if (last_c)   ovf_q <= carry ^ fa_co;
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios plus a random sweep against a+b+cin.
module tb_serial_adder;

  localparam int unsigned W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: unsigned (W+1)-bit sum
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int unsigned t;
    t = int'(a) + int'(b) + (c ? 1 : 0);
    return (W+1)'(t % (1 << (W + 1)));
  endfunction

  // Reference: signed overflow of a+b+cin viewed as W-bit two's complement
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int sa;
    int sb;
    int r;
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    r  = sa + sb + (c ? 1 : 0);
    return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endfunction

  // Issue one request and wait for done; operands are scrambled once accepted
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output int lat, output int bcnt, output bit to);
    bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat  = 1;
    bcnt = bus.busy ? 1 : 0;
    to   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      if (bus.done) begin
        to = 1'b0;
        break;
      end
      if (bus.busy) bcnt++;
    end
  endtask

  task automatic wait_done(output bit to);
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat; int bcnt; bit to;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: busy=%b done=%b sum=%b cout=%b, required all 0", bus.busy, bus.done, bus.sum, bus.cout);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    do_op(W'(7), W'(9), 1'b1, lat, bcnt, to);
    // asynchronous reset mid-cycle while a nonzero result is held
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: busy=%b done=%b sum=%b cout=%b, required all 0", bus.busy, bus.done, bus.sum, bus.cout);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_checks++;
    if (bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: ovf=%b, required 0", bus.ovf);
    end
`endif
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; int bcnt; bit to;
    do_op(W'(3), W'(3), 1'b0, lat, bcnt, to);
    n_checks++;
    if (to || lat != W + 1 || bcnt != W) begin
      n_fail++;
      $display("FAIL basic_timing: timeout=%0d latency=%0d busy=%0d, required 0/%0d/%0d", to, lat, bcnt, W + 1, W);
    end
    n_checks++;
    if (bus.sum !== W'(6) || bus.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: sum=%b cout=%b, required 000110 0", bus.sum, bus.cout);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== W'(6)) begin
      n_fail++;
      $display("FAIL basic_hold: done=%b busy=%b sum=%b, required 0 0 000110", bus.done, bus.busy, bus.sum);
    end
  endtask

  task automatic test_msb_carry();
    int lat; int bcnt; bit to;
    do_op(W'(32), W'(32), 1'b0, lat, bcnt, to);
    n_checks++;
    if (to || bus.sum !== W'(0) || bus.cout !== 1'b1) begin
      n_fail++;
      $display("FAIL msb_carry: timeout=%0d sum=%b cout=%b, required 000000 1", to, bus.sum, bus.cout);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_checks++;
    if (bus.ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL msb_ovf: ovf=%b, required 1", bus.ovf);
    end
`endif
  endtask

  task automatic test_full_ripple();
    int lat; int bcnt; bit to;
    do_op(W'(63), W'(0), 1'b1, lat, bcnt, to);
    n_checks++;
    if (to || bus.sum !== W'(0) || bus.cout !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ripple: timeout=%0d sum=%b cout=%b, required 000000 1", to, bus.sum, bus.cout);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_checks++;
    if (bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ripple_ovf: ovf=%b, required 0", bus.ovf);
    end
`endif
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [W:0] e;
    bus.a = W'(3); bus.b = W'(3); bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = W'(1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(to);
    n_checks++;
    if (to || bus.sum !== W'(6) || bus.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored: timeout=%0d sum=%b cout=%b, required 000110 0", to, bus.sum, bus.cout);
    end
    // start held in the DONE cycle: accepted on the next edge without an IDLE gap
    bus.a = W'(5); bus.b = W'(9); bus.cin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.sum !== W'(0)) begin
      n_fail++;
      $display("FAIL no_idle_gap: busy=%b done=%b sum=%b, required 1 0 000000", bus.busy, bus.done, bus.sum);
    end
    wait_done(to);
    e = ref_sum(W'(5), W'(9), 1'b1);
    n_checks++;
    if (to || {bus.cout, bus.sum} !== e) begin
      n_fail++;
      $display("FAIL b2b_result: timeout=%0d got=%b, required %b", to, {bus.cout, bus.sum}, e);
    end
  endtask

  task automatic test_reset_mid();
    int lat; int bcnt; bit to;
    bus.a = W'(3); bus.b = W'(3); bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%b cout=%b, required all 0", bus.busy, bus.done, bus.sum, bus.cout);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
    do_op(W'(2), W'(2), 1'b0, lat, bcnt, to);
    n_checks++;
    if (to || bus.sum !== W'(4) || bus.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: timeout=%0d sum=%b cout=%b, required 000100 0", to, bus.sum, bus.cout);
    end
  endtask

  task automatic test_random();
    int lat; int bcnt; bit to;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic c;
    logic [W:0] e;
    for (int i = 0; i < 200; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      do_op(a, b, c, lat, bcnt, to);
      e = ref_sum(a, b, c);
      n_checks++;
      if (to || lat != W + 1 || bcnt != W || {bus.cout, bus.sum} !== e) begin
        n_fail++;
        $display("FAIL random[%0d] a=%b b=%b cin=%b: got %b lat=%0d busy=%0d to=%0d, required %b lat=%0d busy=%0d",
                 i, a, b, c, {bus.cout, bus.sum}, lat, bcnt, to, e, W + 1, W);
      end
`ifdef SERIAL_ADD_OVF_EN
      n_checks++;
      if (bus.ovf !== ref_ovf(a, b, c)) begin
        n_fail++;
        $display("FAIL random_ovf[%0d] a=%b b=%b cin=%b: ovf=%b, required %b", i, a, b, c, bus.ovf, ref_ovf(a, b, c));
      end
`endif
      if ($urandom_range(0, 3) != 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_msb_carry();
    test_full_ripple();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_adder
